// File: rtl/rosc_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: counts edges of one selected channel over a
// programmable CLK gate window and drives a divided copy to a pad. Optional macro: ROSC_CNT_SAT_EN.
//
// state  | meaning
// IDLE   | waiting for START; LOAD updates all shadow registers
// ARM    | clear edge counter and overflow flag, load gate down-counter
// GATE   | count selected-channel edges until the gate counter reaches zero
// DONE   | result visible on COUNT/OVF, DONE pulse
module rosc_freq_meter #(
    parameter int N_CH    = 8,
    parameter int CH_W    = 3,
    parameter int GATE_W  = 12,
    parameter int CNT_W   = 16,
    parameter int PAD_DIV = 4
) (
    input  logic              CLK,
    input  logic              RESETB,
    input  logic              LOAD,
    input  logic [CH_W-1:0]   CH_SEL,
    input  logic [GATE_W-1:0] GATE_LEN,
    input  logic              CLK_KILL,
    input  logic              START,
    input  logic [N_CH-1:0]   ROSC_IN,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  COUNT,
    output logic              OVF,
    output logic              PAD_OUT
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_DONE} state_t;

    localparam int          NCH_I    = N_CH;
    localparam logic [CH_W:0] N_CH_L = NCH_I[CH_W:0];

    state_t state, state_nxt;

    logic [N_CH-1:0]    sync1, sync2, hist;
    logic [N_CH-1:0]    edges;
    logic [CH_W-1:0]    sh_ch;
    logic [GATE_W-1:0]  sh_gate;
    logic               sh_kill;
    logic [CH_W-1:0]    ch_eff;
    logic               load_cfg;
    logic               sel_edge;
    logic [GATE_W-1:0]  gate_cnt;
    logic [CNT_W-1:0]   edge_cnt, cnt_nxt;
    logic               ovf_flag, flag_nxt;
    logic               gate_last;
    logic [PAD_DIV-1:0] pad_cnt;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= ROSC_IN;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign edges    = sync2 & ~hist;
    assign sel_edge = edges[sh_ch];
    assign ch_eff   = ({1'b0, CH_SEL} >= N_CH_L) ? '0 : CH_SEL;
    assign load_cfg = LOAD && (state == S_IDLE);

    // Channel and gate are frozen while a measurement runs; the pad kill is not.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            sh_ch   <= '0;
            sh_gate <= '0;
            sh_kill <= 1'b0;
        end else if (LOAD) begin
            sh_kill <= CLK_KILL;
            if (state == S_IDLE) begin
                sh_ch   <= ch_eff;
                sh_gate <= GATE_LEN;
            end
        end
    end

    always_comb begin
        cnt_nxt  = edge_cnt;
        flag_nxt = ovf_flag;
        if (sel_edge) begin
            if (&edge_cnt) begin
                flag_nxt = 1'b1;
`ifdef ROSC_CNT_SAT_EN
                cnt_nxt  = edge_cnt;
`else
                cnt_nxt  = '0;
`endif
            end else begin
                cnt_nxt = edge_cnt + 1'b1;
            end
        end
    end

    assign gate_last = (state == S_GATE) && (gate_cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = S_ARM;
            S_ARM:   state_nxt = S_GATE;
            S_GATE:  if (gate_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) state <= S_IDLE;
        else         state <= state_nxt;
    end

    assign BUSY = (state != S_IDLE);
    assign DONE = (state == S_DONE);

    // Gate counter holds G-1; a zero GATE_LEN wraps to all-ones, giving 2^GATE_W cycles.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            COUNT    <= '0;
            OVF      <= 1'b0;
        end else begin
            case (state)
                S_ARM: begin
                    edge_cnt <= '0;
                    ovf_flag <= 1'b0;
                    gate_cnt <= sh_gate - 1'b1;
                end
                S_GATE: begin
                    edge_cnt <= cnt_nxt;
                    ovf_flag <= flag_nxt;
                    gate_cnt <= gate_cnt - 1'b1;
                    if (gate_last) begin
                        COUNT <= cnt_nxt;
                        OVF   <= flag_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            pad_cnt <= '0;
            PAD_OUT <= 1'b0;
        end else begin
            if (load_cfg && (ch_eff != sh_ch)) pad_cnt <= '0;
            else if (sel_edge)                 pad_cnt <= pad_cnt + 1'b1;
            PAD_OUT <= sh_kill ? 1'b0 : pad_cnt[PAD_DIV-1];
        end
    end

endmodule
